// File: rtl/bus_mux_reg_if.sv
// Bus-mux port bundle: packed sources, one-hot enables, registered bus and conflict monitor outputs.
interface bus_mux_reg_if #(
  parameter int DATA_W = 32,
  parameter int NSRC   = 24,
  parameter int SEL_W  = 5,
  parameter int CNT_W  = 8
);
  logic [NSRC*DATA_W-1:0] src_data;
  logic [NSRC-1:0]        src_out;
  logic                   conflict_ack;
  logic [DATA_W-1:0]      bus_out;
  logic                   bus_valid;
  logic [SEL_W-1:0]       bus_sel;
  logic                   conflict;
  logic [CNT_W-1:0]       conflict_cnt;

  modport master (
    output src_data, src_out, conflict_ack,
    input  bus_out, bus_valid, bus_sel, conflict, conflict_cnt
  );
  modport slave (
    input  src_data, src_out, conflict_ack,
    output bus_out, bus_valid, bus_sel, conflict, conflict_cnt
  );
endinterface

// File: rtl/bus_mux_reg.sv
// Registered priority bus multiplexer: highest set enable drives the bus one cycle later.
// Optional multi-driver monitor built only when BUSMUX_CONFLICT_MON_EN is defined.
module bus_mux_reg_lane #(
  parameter int DATA_W = 32
) (
  input  logic              gnt,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] gated
);
  assign gated = gnt ? data : '0;
endmodule

module bus_mux_reg #(
  parameter int DATA_W = 32,
  parameter int NSRC   = 24,
  parameter int SEL_W  = 5,
  parameter int CNT_W  = 8
) (
  input logic          clock,
  input logic          clear,
  bus_mux_reg_if.slave bus
);
  logic [NSRC-1:0]              higherAny;
  logic [NSRC-1:0]              gnt;
  logic [NSRC-1:0][DATA_W-1:0]  laneData;
  logic [DATA_W-1:0]            muxData;
  logic [SEL_W-1:0]             win;
  logic                         anyOut;

  // A lane is granted only if no higher-index enable is set.
  always_comb begin
    higherAny = '0;
    for (int i = NSRC - 2; i >= 0; i--)
      higherAny[i] = higherAny[i+1] | bus.src_out[i+1];
  end

  assign gnt    = bus.src_out & ~higherAny;
  assign anyOut = |bus.src_out;

  for (genvar g = 0; g < NSRC; g++) begin : gLane
    bus_mux_reg_lane #(.DATA_W(DATA_W)) uLane (
      .gnt   (gnt[g]),
      .data  (bus.src_data[g*DATA_W +: DATA_W]),
      .gated (laneData[g])
    );
  end

  always_comb begin
    muxData = '0;
    win     = '0;
    for (int i = 0; i < NSRC; i++) begin
      muxData = muxData | laneData[i];
      if (gnt[i]) win = SEL_W'(i);
    end
  end

  // Bus keeper: data and select only move when some source drives.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      bus.bus_out   <= '0;
      bus.bus_sel   <= '0;
      bus.bus_valid <= 1'b0;
    end else begin
      bus.bus_valid <= anyOut;
      if (anyOut) begin
        bus.bus_out <= muxData;
        bus.bus_sel <= win;
      end
    end
  end

`ifdef BUSMUX_CONFLICT_MON_EN
  logic             multi;
  logic [CNT_W-1:0] cnt;
  logic             conf;

  // Clearing the lowest set bit leaves something only when two or more are set.
  assign multi = |(bus.src_out & (bus.src_out - 1'b1));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      conf <= 1'b0;
      cnt  <= '0;
    end else if (multi) begin
      conf <= 1'b1;
      if (bus.conflict_ack)  cnt <= CNT_W'(1);
      else if (cnt != '1)    cnt <= cnt + 1'b1;
    end else if (bus.conflict_ack) begin
      conf <= 1'b0;
      cnt  <= '0;
    end
  end

  assign bus.conflict     = conf;
  assign bus.conflict_cnt = cnt;
`else
  logic unusedAck;
  assign unusedAck        = bus.conflict_ack;
  assign bus.conflict     = 1'b0;
  assign bus.conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_bus_mux_reg.sv
// Scoreboard bench for bus_mux_reg: driver queues hand-computed expectations, monitor checks after each edge.
module tb_bus_mux_reg;
  localparam int DATA_W = 32;
  localparam int NSRC   = 24;
  localparam int SEL_W  = 5;
  localparam int CNT_W  = 2;
`ifdef BUSMUX_CONFLICT_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] bus;
    logic [SEL_W-1:0]  sel;
    logic              vld;
    logic              conf;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  logic clock;
  logic clear;
  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t e;
  logic [NSRC-1:0][DATA_W-1:0] srcArr;

  bus_mux_reg_if #(.DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

  bus_mux_reg #(.DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  assign bus.src_data = srcArr;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic drive(input logic [NSRC-1:0] so, input logic ack,
                       input logic [DATA_W-1:0] eb, input logic [SEL_W-1:0] es,
                       input logic ev, input logic ec, input logic [CNT_W-1:0] en);
    exp_t x;
    @(negedge clock);
    bus.src_out      = so;
    bus.conflict_ack = ack;
    x.bus  = eb;
    x.sel  = es;
    x.vld  = ev;
    x.conf = MON ? ec : 1'b0;
    x.cnt  = MON ? en : '0;
    q.push_back(x);
  endtask

  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("bus_out",      bus.bus_out,      e.bus);
      chk("bus_sel",      32'(bus.bus_sel), 32'(e.sel));
      chk("bus_valid",    32'(bus.bus_valid), 32'(e.vld));
      chk("conflict",     32'(bus.conflict), 32'(e.conf));
      chk("conflict_cnt", 32'(bus.conflict_cnt), 32'(e.cnt));
    end
  end

  task automatic chkReset(input string tag);
    chk({tag, "_bus"},   bus.bus_out, 32'h0);
    chk({tag, "_vld"},   32'(bus.bus_valid), 32'h0);
    chk({tag, "_sel"},   32'(bus.bus_sel), 32'h0);
    chk({tag, "_conf"},  32'(bus.conflict), 32'h0);
    chk({tag, "_cnt"},   32'(bus.conflict_cnt), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < NSRC; i++) srcArr[i] = 32'hA000_0000 | 32'(i);
    srcArr[0]  = 32'h0000_0001;
    srcArr[3]  = 32'h0000_0033;
    srcArr[5]  = 32'h0000_00A5;
    srcArr[20] = 32'h0000_0040;
    srcArr[21] = 32'hDEAD_BEEF;
    srcArr[23] = 32'h1234_5678;
    bus.src_out      = '0;
    bus.conflict_ack = 1'b0;
    clear = 1'b0;
    #3 clear = 1'b1;
    #1 chkReset("por");
    @(negedge clock);
    clear = 1'b0;

    // Load R5, then reset between edges with R5 still enabled
    drive(24'(1) << 5, 1'b0, 32'h0000_00A5, 5'd5, 1'b1, 1'b0, 2'd0);
    @(negedge clock);
    #2 clear = 1'b1;
    #1 chkReset("midrst");
    @(negedge clock);
    chkReset("rsthold");
    clear = 1'b0;
    bus.src_out = '0;
    drive('0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0);

    // Single driver MDR, then idle hold
    drive(24'(1) << 21, 1'b0, 32'hDEAD_BEEF, 5'd21, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++)
      drive('0, 1'b0, 32'hDEAD_BEEF, 5'd21, 1'b0, 1'b0, 2'd0);

    // R0 + PC conflict held 5 cycles: count saturates at 3
    drive(24'h10_0001, 1'b0, 32'h40, 5'd20, 1'b1, 1'b1, 2'd1);
    drive(24'h10_0001, 1'b0, 32'h40, 5'd20, 1'b1, 1'b1, 2'd2);
    drive(24'h10_0001, 1'b0, 32'h40, 5'd20, 1'b1, 1'b1, 2'd3);
    drive(24'h10_0001, 1'b0, 32'h40, 5'd20, 1'b1, 1'b1, 2'd3);
    drive(24'h10_0001, 1'b0, 32'h40, 5'd20, 1'b1, 1'b1, 2'd3);

    // Ack alongside a new conflict (C + R3), then ack with a single driver
    drive(24'h80_0008, 1'b1, 32'h1234_5678, 5'd23, 1'b1, 1'b1, 2'd1);
    drive(24'h00_0008, 1'b1, 32'h0000_0033, 5'd3,  1'b1, 1'b0, 2'd0);

    // C beats MDR; sticky through idle; ack while idle clears
    drive(24'hA0_0000, 1'b0, 32'h1234_5678, 5'd23, 1'b1, 1'b1, 2'd1);
    drive('0,          1'b0, 32'h1234_5678, 5'd23, 1'b0, 1'b1, 2'd1);
    drive('0,          1'b1, 32'h1234_5678, 5'd23, 1'b0, 1'b0, 2'd0);

    @(negedge clock);
    bus.conflict_ack = 1'b0;
    repeat (3) @(negedge clock);
    chk("drain", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
